delay_buf_arbiter: RTL

DELAY_BUF_ARBITER -- requirements
Module: delay_buf_arbiter

---
 rtl/delay_buf_arbiter_pkg.sv | 19 +
 rtl/delay_buf_arbiter_if.sv | 41 ++++
 rtl/delay_buf_arbiter_delay_line.sv | 50 +++++
 rtl/delay_buf_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/delay_buf_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// FHE_ALU_PKG
// Purpose : shared constants for the delayed-buffer arbiter slice, plus a small
//           wrap-around increment helper used for round-robin and FIFO pointers.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package FHE_ALU_PKG;

    localparam int FSIZE         = 16;
    localparam int BUF_NUM_REQ   = 4;
    localparam int BUF_CYCLES    = 2;
    localparam int BUF_OUT_DEPTH = 4;

    // Cyclic increment of an index in the range 0..n-1.
    function automatic int nextIndex(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/delay_buf_arbiter_if.sv
// ---------------------------------------------------------------------------
// delay_buf_arbiter_if
// Purpose : bundles the requester side and the response side of the arbiter.
// Signals : en, req_valid[NUM_REQ], req_data[NUM_REQ][DATA_SIZE], req_ready[NUM_REQ],
//           resp_valid, resp_ready, resp_id, resp_data, credits, busy
// Modports: slave  - the arbiter itself
//           master - requesters/consumer driving it
// ---------------------------------------------------------------------------
interface delay_buf_arbiter_if
    import FHE_ALU_PKG::*;
#(
    parameter int NUM_REQ   = BUF_NUM_REQ,
    parameter int DATA_SIZE = FSIZE,
    parameter int OUT_DEPTH = BUF_OUT_DEPTH
) ();

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CRED_W = $clog2(OUT_DEPTH + 1);

    logic                               en;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0]  req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               resp_valid;
    logic                               resp_ready;
    logic [ID_W-1:0]                    resp_id;
    logic [DATA_SIZE-1:0]               resp_data;
    logic [CRED_W-1:0]                  credits;
    logic                               busy;

    modport slave (
        input  en, req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, credits, busy
    );

    modport master (
        output en, req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, credits, busy
    );

endinterface

// File: rtl/delay_buf_arbiter_delay_line.sv
// ---------------------------------------------------------------------------
// tagged_delay_line
// Purpose : fixed-latency shift line carrying {valid, id, data}; every stage
//           advances every cycle, no stall.
// Ports   : clk, rstn       - clock, async active-low reset (valid bits only)
//           i_valid/i_id/i_data - stage-0 input
//           o_valid/o_id/o_data - last-stage output
//           o_anyValid      - any stage holds a valid item
// ---------------------------------------------------------------------------
module tagged_delay_line #(
    parameter int CYCLES = 2,
    parameter int ID_W   = 2,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    input  logic [ID_W-1:0]   i_id,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [ID_W-1:0]   o_id,
    output logic [DATA_W-1:0] o_data,
    output logic              o_anyValid
);

    logic [CYCLES-1:0]             r_valid;
    logic [CYCLES-1:0][ID_W-1:0]   r_id;
    logic [CYCLES-1:0][DATA_W-1:0] r_data;

    // Shift towards the MSB; the size cast drops the oldest stage, which
    // keeps the expression legal for CYCLES == 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
        end else begin
            r_valid <= CYCLES'({r_valid, i_valid});
        end
    end

    always_ff @(posedge clk) begin
        r_id   <= (CYCLES * ID_W)'({r_id, i_id});
        r_data <= (CYCLES * DATA_W)'({r_data, i_data});
    end

    assign o_valid    = r_valid[CYCLES-1];
    assign o_id       = r_id[CYCLES-1];
    assign o_data     = r_data[CYCLES-1];
    assign o_anyValid = |r_valid;

endmodule

// File: rtl/delay_buf_arbiter.sv
// ---------------------------------------------------------------------------
// delay_buf_arbiter
// Purpose : round-robin arbiter over NUM_REQ requesters; the winner's {id, data}
//           passes through a CYCLES-deep delay line into a FWFT response queue.
//           Queue slots are reserved by credits at grant time so the queue can
//           never overflow and delay-line outputs are never dropped.
// Ports   : clk  - rising-edge clock
//           rstn - asynchronous active-low reset
//           bus  - delay_buf_arbiter_if.slave (request/response handshakes,
//                  credits, busy)
// ---------------------------------------------------------------------------
module delay_buf_arbiter
    import FHE_ALU_PKG::*;
#(
    parameter int DATA_SIZE = FSIZE,
    parameter int NUM_REQ   = BUF_NUM_REQ,
    parameter int CYCLES    = BUF_CYCLES,
    parameter int OUT_DEPTH = BUF_OUT_DEPTH
) (
    input logic                clk,
    input logic                rstn,
    delay_buf_arbiter_if.slave bus
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CRED_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [ID_W-1:0]      r_rrPtr;
    logic [CRED_W-1:0]    r_credits;
    logic                 w_found;
    logic                 w_issue;
    logic                 w_pop;
    logic [ID_W-1:0]      w_grantIdx;
    logic [NUM_REQ-1:0]   w_grant;

    logic                 w_dlValid;
    logic                 w_dlAny;
    logic [ID_W-1:0]      w_dlId;
    logic [DATA_SIZE-1:0] w_dlData;

    logic [ID_W-1:0]      r_qId   [OUT_DEPTH];
    logic [DATA_SIZE-1:0] r_qData [OUT_DEPTH];
    logic [PTR_W-1:0]     r_rdPtr;
    logic [PTR_W-1:0]     r_wrPtr;
    logic [CRED_W-1:0]    r_count;

    // Cyclic search starting at the round-robin pointer. The grant is also
    // gated by rstn so req_ready stays low while reset is held.
    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rrPtr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && bus.req_valid[ID_W'(idx)]) begin
                w_found    = 1'b1;
                w_grantIdx = ID_W'(idx);
            end
        end
        w_issue = rstn && bus.en && (r_credits != '0) && w_found;
        w_grant = '0;
        if (w_issue) begin
            w_grant[w_grantIdx] = 1'b1;
        end
    end

    assign w_pop = (r_count != '0) && bus.resp_ready;

    // Credits track reserved slots: a grant reserves one, a pop returns one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rrPtr   <= '0;
            r_credits <= CRED_W'(OUT_DEPTH);
        end else begin
            if (w_issue) begin
                r_rrPtr <= ID_W'(nextIndex(int'(w_grantIdx), NUM_REQ));
            end
            if (w_issue && !w_pop) begin
                r_credits <= r_credits - CRED_W'(1);
            end else if (!w_issue && w_pop) begin
                r_credits <= r_credits + CRED_W'(1);
            end
        end
    end

    tagged_delay_line #(
        .CYCLES (CYCLES),
        .ID_W   (ID_W),
        .DATA_W (DATA_SIZE)
    ) u_delayLine (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (w_issue),
        .i_id       (w_grantIdx),
        .i_data     (bus.req_data[w_grantIdx]),
        .o_valid    (w_dlValid),
        .o_id       (w_dlId),
        .o_data     (w_dlData),
        .o_anyValid (w_dlAny)
    );

    // The delay-line output is pushed unconditionally: its slot was already
    // reserved by the credit taken at grant time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_dlValid) begin
                r_wrPtr <= PTR_W'(nextIndex(int'(r_wrPtr), OUT_DEPTH));
            end
            if (w_pop) begin
                r_rdPtr <= PTR_W'(nextIndex(int'(r_rdPtr), OUT_DEPTH));
            end
            if (w_dlValid && !w_pop) begin
                r_count <= r_count + CRED_W'(1);
            end else if (!w_dlValid && w_pop) begin
                r_count <= r_count - CRED_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_dlValid) begin
            r_qId[r_wrPtr]   <= w_dlId;
            r_qData[r_wrPtr] <= w_dlData;
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.resp_valid = (r_count != '0);
    assign bus.resp_id    = r_qId[r_rdPtr];
    assign bus.resp_data  = r_qData[r_rdPtr];
    assign bus.credits    = r_credits;
    assign bus.busy       = w_dlAny || (r_count != '0);

endmodule
